// File: rtl/reg_write_router.sv
// Register-write address router: run-time range table, one-hot target handshake
// with a cycle timeout, and one status response per write.
module reg_write_router #(
    parameter int NUM_TGT = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int TGT_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               reg_valid_i,
    input  logic [TGT_W-1:0]   reg_tgt_i,
    input  logic [ADDR_W-1:0]  reg_start_i,
    input  logic [ADDR_W-1:0]  reg_end_i,
    output logic               reg_err_o,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [ADDR_W-1:0]  req_addr_i,
    input  logic [DATA_W-1:0]  req_data_i,
    output logic [NUM_TGT-1:0] tgt_valid_o,
    output logic [ADDR_W-1:0]  tgt_addr_o,
    output logic [DATA_W-1:0]  tgt_data_o,
    input  logic [NUM_TGT-1:0] tgt_ack_i,
    output logic               rsp_valid_o,
    output logic [1:0]         rsp_status_o,
    output logic [TGT_W-1:0]   rsp_tgt_o,
    output logic [15:0]        cnt_ok_o,
    output logic [15:0]        cnt_err_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_UNMAPPED = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_RESP} state_t;

    logic [ADDR_W-1:0]  start_q [NUM_TGT];
    logic [ADDR_W-1:0]  end_q   [NUM_TGT];
    logic [NUM_TGT-1:0] valid_q;
    logic               reg_err_q;
    logic               reg_ok_d;

    state_t             state_q;
    logic               req_ready_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [TGT_W-1:0]   idx_q;
    logic [TMR_W-1:0]   timer_q;
    logic [NUM_TGT-1:0] tgt_valid_q;
    logic [ADDR_W-1:0]  tgt_addr_q;
    logic [DATA_W-1:0]  tgt_data_q;
    logic               rsp_valid_q;
    logic [1:0]         rsp_status_q;
    logic [TGT_W-1:0]   rsp_tgt_q;
    logic [15:0]        cnt_ok_q;
    logic [15:0]        cnt_err_q;
    logic               hit_d;
    logic [TGT_W-1:0]   hit_idx_d;

    assign reg_ok_d = (int'(reg_tgt_i) < NUM_TGT) && (reg_start_i <= reg_end_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            reg_err_q <= 1'b0;
            for (int i = 0; i < NUM_TGT; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
            end
        end else begin
            reg_err_q <= reg_valid_i && !reg_ok_d;
            for (int i = 0; i < NUM_TGT; i++) begin
                if (reg_valid_i && reg_ok_d && (reg_tgt_i == TGT_W'(i))) begin
                    start_q[i] <= reg_start_i;
                    end_q[i]   <= reg_end_i;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (valid_q[i] && (addr_q >= start_q[i]) && (addr_q <= end_q[i])) begin
                hit_d     = 1'b1;
                hit_idx_d = TGT_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            addr_q       <= '0;
            data_q       <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            tgt_valid_q  <= '0;
            tgt_addr_q   <= '0;
            tgt_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_tgt_q    <= '0;
            cnt_ok_q     <= '0;
            cnt_err_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        addr_q      <= req_addr_i;
                        data_q      <= req_data_i;
                        req_ready_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (hit_d) begin
                        idx_q       <= hit_idx_d;
                        timer_q     <= '0;
                        tgt_valid_q <= NUM_TGT'(1) << hit_idx_d;
                        tgt_addr_q  <= addr_q;
                        tgt_data_q  <= data_q;
                        state_q     <= S_ISSUE;
                    end else begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_UNMAPPED;
                        rsp_tgt_q    <= '0;
                        if (cnt_err_q != 16'hFFFF) cnt_err_q <= cnt_err_q + 16'd1;
                        state_q      <= S_RESP;
                    end
                end
                S_ISSUE: begin
                    // Ack is checked before expiry so a last-cycle ack still reports OK.
                    if (tgt_ack_i[idx_q] || (timer_q == TMR_W'(TIMEOUT - 1))) begin
                        tgt_valid_q <= '0;
                        tgt_addr_q  <= '0;
                        tgt_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_tgt_q   <= idx_q;
                        state_q     <= S_RESP;
                        if (tgt_ack_i[idx_q]) begin
                            rsp_status_q <= ST_OK;
                            if (cnt_ok_q != 16'hFFFF) cnt_ok_q <= cnt_ok_q + 16'd1;
                        end else begin
                            rsp_status_q <= ST_TIMEOUT;
                            if (cnt_err_q != 16'hFFFF) cnt_err_q <= cnt_err_q + 16'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_err_o    = reg_err_q;
    assign req_ready_o  = req_ready_q;
    assign tgt_valid_o  = tgt_valid_q;
    assign tgt_addr_o   = tgt_addr_q;
    assign tgt_data_o   = tgt_data_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_tgt_o    = rsp_tgt_q;
    assign cnt_ok_o     = cnt_ok_q;
    assign cnt_err_o    = cnt_err_q;

endmodule

// File: tb/tb_reg_write_router.sv
// Bench for reg_write_router: table of register/write vectors with a response
// scoreboard, plus a hand-written reset-during-issue sequence.
module tb_reg_write_router;

    localparam int NUM_TGT = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_valid = 1'b0;
    logic [1:0]  reg_tgt = '0;
    logic [31:0] reg_start = '0;
    logic [31:0] reg_end = '0;
    logic        reg_err;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  tgt_valid;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_data;
    logic [3:0]  tgt_ack = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [1:0]  rsp_tgt;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    int total = 0;
    int bad = 0;
    int expOk = 0;
    int expErr = 0;
    logic [3:0] sb [$];
    logic [3:0] sbHead;

    typedef struct {
        bit          doReg;
        logic [1:0]  rTgt;
        logic [31:0] rStart;
        logic [31:0] rEnd;
        bit          rErr;
        logic [31:0] addr;
        logic [31:0] data;
        int          ackDly;
        logic [3:0]  oneHot;
        logic [1:0]  st;
        logic [1:0]  tgt;
    } vec_t;

    vec_t vecs [$];

    reg_write_router #(
        .NUM_TGT(NUM_TGT),
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_valid_i (reg_valid),
        .reg_tgt_i   (reg_tgt),
        .reg_start_i (reg_start),
        .reg_end_i   (reg_end),
        .reg_err_o   (reg_err),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .tgt_valid_o (tgt_valid),
        .tgt_addr_o  (tgt_addr),
        .tgt_data_o  (tgt_data),
        .tgt_ack_i   (tgt_ack),
        .rsp_valid_o (rsp_valid),
        .rsp_status_o(rsp_status),
        .rsp_tgt_o   (rsp_tgt),
        .cnt_ok_o    (cnt_ok),
        .cnt_err_o   (cnt_err)
    );

    // Free-running clock; stimulus and sampling both happen on the falling edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                sbHead = sb.pop_front();
                checkOutput("rsp_status", 64'(rsp_status), 64'(sbHead[3:2]));
                checkOutput("rsp_tgt", 64'(rsp_tgt), 64'(sbHead[1:0]));
            end
        end
    end

    task automatic applyRegistration(input logic [1:0] t, input logic [31:0] s,
                                     input logic [31:0] e, input bit expErrPulse);
        reg_valid = 1'b1;
        reg_tgt   = t;
        reg_start = s;
        reg_end   = e;
        @(negedge clk);
        reg_valid = 1'b0;
        checkOutput("reg_err", 64'(reg_err), 64'(expErrPulse));
        @(negedge clk);
        checkOutput("reg_err_clear", 64'(reg_err), 64'(0));
    endtask

    // Drives one write and walks its cycle-by-cycle timeline from the accept edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input int ackDly, input logic [3:0] oneHot,
                                 input logic [1:0] st, input logic [1:0] tgt);
        int held;
        int expHeld;
        checkOutput("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        sb.push_back({st, tgt});
        if (st == 2'b00) expOk++;
        else expErr++;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        checkOutput("req_ready_busy", 64'(req_ready), 64'(0));
        @(negedge clk);
        if (oneHot != 4'b0000) begin
            checkOutput("tgt_valid", 64'(tgt_valid), 64'(oneHot));
            checkOutput("tgt_addr", 64'(tgt_addr), 64'(addr));
            checkOutput("tgt_data", 64'(tgt_data), 64'(data));
            expHeld = (ackDly < 0) ? TIMEOUT : ackDly + 1;
            held = 0;
            while (tgt_valid != 4'b0000 && held < 100) begin
                if (held == ackDly) tgt_ack = oneHot;
                held++;
                @(negedge clk);
                tgt_ack = '0;
            end
            checkOutput("tgt_valid_cycles", 64'(held), 64'(expHeld));
        end else begin
            checkOutput("tgt_valid_unmapped", 64'(tgt_valid), 64'(0));
        end
        checkOutput("rsp_latency", 64'(rsp_valid), 64'(1));
        @(negedge clk);
        checkOutput("rsp_pulse_end", 64'(rsp_valid), 64'(0));
        checkOutput("tgt_valid_idle", 64'(tgt_valid), 64'(0));
        checkOutput("tgt_data_idle", 64'(tgt_data), 64'(0));
        checkOutput("req_ready_back", 64'(req_ready), 64'(1));
        checkOutput("cnt_ok", 64'(cnt_ok), 64'(expOk));
        checkOutput("cnt_err", 64'(cnt_err), 64'(expErr));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Initial table is slots 0/1/2 = [100,200]/[201,300]/[301,400]; later rows edit it.
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd100, 32'd10,  0, 4'b0001, 2'd0, 2'd0});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd210, 32'd21,  0, 4'b0010, 2'd0, 2'd1});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd500, 32'd50, -1, 4'b0000, 2'd1, 2'd0});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd200, 32'd20,  0, 4'b0001, 2'd0, 2'd0});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd201, 32'd22,  0, 4'b0010, 2'd0, 2'd1});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd99,  32'd9,  -1, 4'b0000, 2'd1, 2'd0});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd400, 32'd40,  3, 4'b0100, 2'd0, 2'd2});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd301, 32'd31, 15, 4'b0100, 2'd0, 2'd2});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd150, 32'd15, -1, 4'b0001, 2'd2, 2'd0});
        vecs.push_back('{1, 2'd3, 32'd0,   32'hFFFF_FFFF,  0, 32'd99,  32'd99,  0, 4'b1000, 2'd0, 2'd3});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd500, 32'd55,  2, 4'b1000, 2'd0, 2'd3});
        vecs.push_back('{1, 2'd2, 32'd400, 32'd300,        1, 32'd350, 32'd35,  0, 4'b0100, 2'd0, 2'd2});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd450, 32'd45,  0, 4'b1000, 2'd0, 2'd3});
        vecs.push_back('{1, 2'd1, 32'd100, 32'd200,        0, 32'd150, 32'd16,  1, 4'b0001, 2'd0, 2'd0});
        vecs.push_back('{0, 2'd0, 32'd0,   32'd0,          0, 32'd250, 32'd25,  0, 4'b1000, 2'd0, 2'd3});

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'(1));
        checkOutput("reset_tgt_valid", 64'(tgt_valid), 64'(0));
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("reset_reg_err", 64'(reg_err), 64'(0));
        checkOutput("reset_cnt_ok", 64'(cnt_ok), 64'(0));
        checkOutput("reset_cnt_err", 64'(cnt_err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        applyRegistration(2'd0, 32'd100, 32'd200, 1'b0);
        applyRegistration(2'd1, 32'd201, 32'd300, 1'b0);
        applyRegistration(2'd2, 32'd301, 32'd400, 1'b0);

        foreach (vecs[i]) begin
            if (vecs[i].doReg)
                applyRegistration(vecs[i].rTgt, vecs[i].rStart, vecs[i].rEnd, vecs[i].rErr);
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].ackDly,
                          vecs[i].oneHot, vecs[i].st, vecs[i].tgt);
        end

        // Reset while a write is being issued: abort with no response, table cleared.
        checkOutput("pre_abort_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = 32'd120;
        req_data  = 32'd77;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_tgt_valid_before", 64'(tgt_valid), 64'(4'b0001));
        rst = 1'b1;
        #1;
        checkOutput("abort_tgt_valid", 64'(tgt_valid), 64'(0));
        checkOutput("abort_req_ready", 64'(req_ready), 64'(1));
        checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        expOk = 0;
        expErr = 0;
        repeat (4) @(negedge clk);
        checkOutput("abort_cnt_ok", 64'(cnt_ok), 64'(0));
        checkOutput("abort_cnt_err", 64'(cnt_err), 64'(0));
        applyStimulus(32'd100, 32'd11, -1, 4'b0000, 2'd1, 2'd0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
